// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the multi-road traffic controller.
//   state_t : 3-bit FSM state encoding. It is also driven out on the debug
//             'state' port, so these values are visible to the display path.
//   lamp_t  : one-hot lamp encoding, ordered {red, yellow, green}.
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN    = 3'd0,
        MAIN_YELLOW   = 3'd1,
        CLEAR_TO_SIDE = 3'd2,
        SIDE_GREEN    = 3'd3,
        SIDE_YELLOW   = 3'd4,
        CLEAR_TO_MAIN = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        LAMP_RED    = 3'b100,
        LAMP_YELLOW = 3'b010,
        LAMP_GREEN  = 3'b001
    } lamp_t;

endpackage

// File: rtl/car_sensor_sync_n.sv
// ---------------------------------------------------------------------------
// car_sensor_sync_n
// N-wide two-flop synchronizer for the asynchronous side-road car sensors.
// Ports:
//   clock    : system clock
//   reset    : synchronous, active-low reset; clears both flop stages
//   async_in : raw sensor inputs (asynchronous to clock)
//   sync_out : synchronized sensor levels, two clocks after sampling
// ---------------------------------------------------------------------------
module car_sensor_sync_n #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] async_in,
    output logic [N-1:0] sync_out
);

    logic [N-1:0] meta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            meta     <= '0;
            sync_out <= '0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/traffic_controller_multi.sv
// ---------------------------------------------------------------------------
// traffic_controller_multi
// Arbitrates one main road against N_SIDE side roads. Side roads are served
// round-robin. Every phase change passes through yellow and an all-red
// clearance. The timer and the FSM advance only on 'tick'.
// Ports:
//   clock, reset        : system clock, synchronous active-low reset
//   tick                : one-cycle timing enable
//   car_async           : raw side-road sensors
//   t_main_min, t_side,
//   t_yellow, t_allred  : phase durations in ticks, sampled on state entry
//   main_red/yellow/green : main-road lamps
//   side_red/yellow/green : per-side lamps, one bit per side road
//   active_side         : side chosen for the current or next side phase
//   time_remaining      : current timer value
//   state               : FSM state encoding, for debug and display
// ---------------------------------------------------------------------------
module traffic_controller_multi
    import traffic_pkg::*;
#(
    parameter int N_SIDE = 2,
    parameter int TW     = 4,
    parameter int IW     = (N_SIDE > 1) ? $clog2(N_SIDE) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic [N_SIDE-1:0] car_async,
    input  logic [TW-1:0]     t_main_min,
    input  logic [TW-1:0]     t_side,
    input  logic [TW-1:0]     t_yellow,
    input  logic [TW-1:0]     t_allred,
    output logic              main_red,
    output logic              main_yellow,
    output logic              main_green,
    output logic [N_SIDE-1:0] side_red,
    output logic [N_SIDE-1:0] side_yellow,
    output logic [N_SIDE-1:0] side_green,
    output logic [IW-1:0]     active_side,
    output logic [TW-1:0]     time_remaining,
    output logic [2:0]        state
);

    localparam logic [TW-1:0] ONE = TW'(1);

    state_t            state_q;
    state_t            next_state;
    logic [TW-1:0]     next_dur;
    logic [N_SIDE-1:0] car_sync;
    logic [N_SIDE-1:0] pending;
    logic [N_SIDE-1:0] pending_next;
    logic [N_SIDE-1:0] req;
    logic [IW-1:0]     last_served;
    logic [IW-1:0]     sel_side;
    int                start_idx;
    logic              exit_ok;
    logic              advance;
    lamp_t             main_lamp;
    lamp_t             side_lamp;

    car_sensor_sync_n #(.N(N_SIDE)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (car_async),
        .sync_out (car_sync)
    );

    // Main green is the only phase that waits for demand; all others time out.
    // The timer has expired once it reaches 1 (a loaded 0 also counts).
    assign exit_ok = (state_q != MAIN_GREEN) || (|pending);
    assign advance = tick && (time_remaining <= ONE) && exit_ok;

    // Successor state and the duration it loads on entry.
    always_comb begin
        next_state = MAIN_GREEN;
        next_dur   = t_main_min;
        case (state_q)
            MAIN_GREEN: begin
                next_state = MAIN_YELLOW;
                next_dur   = t_yellow;
            end
            MAIN_YELLOW: begin
                next_state = CLEAR_TO_SIDE;
                next_dur   = t_allred;
            end
            CLEAR_TO_SIDE: begin
                next_state = SIDE_GREEN;
                next_dur   = t_side;
            end
            SIDE_GREEN: begin
                next_state = SIDE_YELLOW;
                next_dur   = t_yellow;
            end
            SIDE_YELLOW: begin
                next_state = CLEAR_TO_MAIN;
                next_dur   = t_allred;
            end
            default: begin
                next_state = MAIN_GREEN;
                next_dur   = t_main_min;
            end
        endcase
    end

    // Round-robin pick: lowest pending index at or above start_idx, falling
    // back to the lowest pending index overall (the wrap-around case). The
    // second loop overrides the first only when a candidate >= start exists.
    always_comb begin
        sel_side  = '0;
        start_idx = (int'(last_served) >= N_SIDE - 1) ? 0 : int'(last_served) + 1;
        for (int k = N_SIDE - 1; k >= 0; k--) begin
            if (pending[k]) begin
                sel_side = IW'(k);
            end
        end
        for (int k = N_SIDE - 1; k >= 0; k--) begin
            if (pending[k] && (k >= start_idx)) begin
                sel_side = IW'(k);
            end
        end
    end

    // Sticky request latch. A car arriving at the road that is currently
    // being served is dropped, and the served road's bit clears as its
    // green phase begins.
    always_comb begin
        req = car_sync;
        if ((state_q == SIDE_GREEN) || (state_q == SIDE_YELLOW)) begin
            req[active_side] = 1'b0;
        end
        pending_next = pending | req;
        if (advance && (state_q == CLEAR_TO_SIDE)) begin
            pending_next[active_side] = 1'b0;
        end
    end

    // Main FSM with its phase timer. The arbitration result is captured when
    // main green ends, so active_side is stable for the whole side phase.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= MAIN_GREEN;
            time_remaining <= t_main_min;
            pending        <= '0;
            active_side    <= '0;
            last_served    <= IW'(N_SIDE - 1);
        end else begin
            pending <= pending_next;
            if (tick) begin
                if (advance) begin
                    state_q        <= next_state;
                    time_remaining <= next_dur;
                    if (state_q == MAIN_GREEN) begin
                        active_side <= sel_side;
                        last_served <= sel_side;
                    end
                end else if (time_remaining > ONE) begin
                    time_remaining <= time_remaining - ONE;
                end
            end
        end
    end

    // Lamp decode straight from the state register.
    always_comb begin
        case (state_q)
            MAIN_GREEN:  main_lamp = LAMP_GREEN;
            MAIN_YELLOW: main_lamp = LAMP_YELLOW;
            default:     main_lamp = LAMP_RED;
        endcase
        case (state_q)
            SIDE_GREEN:  side_lamp = LAMP_GREEN;
            SIDE_YELLOW: side_lamp = LAMP_YELLOW;
            default:     side_lamp = LAMP_RED;
        endcase
    end

    assign {main_red, main_yellow, main_green} = main_lamp;

    // Only the selected side ever leaves red.
    always_comb begin
        side_red    = '1;
        side_yellow = '0;
        side_green  = '0;
        for (int k = 0; k < N_SIDE; k++) begin
            if (IW'(k) == active_side) begin
                {side_red[k], side_yellow[k], side_green[k]} = side_lamp;
            end
        end
    end

    assign state = state_q;

endmodule

// File: doc/traffic_controller_multi.md
# traffic_controller_multi

Parametrised successor to the single highway/country-road controller. It arbitrates one main road against `N_SIDE` side roads, each with its own asynchronous car sensor. Side roads are served round-robin, and each phase change passes through yellow and a programmable all-red clearance. It sits at the top of the traffic design, fed by a one-second `tick` enable, and drives the light outputs and the remaining-time display path.

## Interface
Parameters:
- `N_SIDE`, default 2: number of side roads, 1..8.
- `TW`, default 4: width of the duration inputs and the timer.
- `IW`, derived: max(1, clog2(`N_SIDE`)), width of the side index.

Ports:
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-low; 0 at a rising edge resets the block.
- `tick`  input  1  one-cycle timing enable; timer and FSM advance only when `tick`=1.
- `car_async`  input  N_SIDE  raw side-road sensors, asynchronous.
- `t_main_min`  input  TW  minimum main-green duration, in ticks.
- `t_side`  input  TW  side-green duration, in ticks.
- `t_yellow`  input  TW  yellow duration, in ticks.
- `t_allred`  input  TW  all-red clearance duration, in ticks.
- `main_red`, `main_yellow`, `main_green`  output  1 each  main-road lamps, exactly one high.
- `side_red`, `side_yellow`, `side_green`  output  N_SIDE each  per-side lamps; exactly one of the three bits is high for each index.
- `active_side`  output  IW  side selected for the current or next side phase.
- `time_remaining`  output  TW  current timer value.
- `state`  output  3  FSM state encoding, for debug and display.

## Operation
- FSM states:
  - MAIN_GREEN, then MAIN_YELLOW, then CLEAR_TO_SIDE (all red).
  - Then SIDE_GREEN, then SIDE_YELLOW, then CLEAR_TO_MAIN (all red), then back to MAIN_GREEN.
- Lamps:
  - Main road: green in MAIN_GREEN, yellow in MAIN_YELLOW, red otherwise.
  - Side road `active_side`: green in SIDE_GREEN, yellow in SIDE_YELLOW, red otherwise.
  - All other side roads: always red.
- Timer:
  - On entry to a state, `time_remaining` loads that state's duration input, sampled at that edge.
  - Later changes to the duration inputs have no effect until the next entry.
- Per tick:
  - If `time_remaining` ≤ 1 and the exit condition holds, the FSM transitions.
  - Otherwise, if `time_remaining` > 1, it decrements.
  - Otherwise it holds.
  - A duration of 0 or 1 therefore gives a 1-tick state.
- Exit conditions:
  - MAIN_GREEN exits only if any `pending` bit is set.
  - Every other state exits unconditionally.
  - With no requests, MAIN_GREEN holds indefinitely with `time_remaining`=1.
- Sensors:
  - Each `car_async` bit passes through a 2-FF synchronizer.
  - A synchronized 1 sets `pending[k]`, which is sticky.
  - `pending[k]` is cleared on entry to SIDE_GREEN with `active_side`=k.
  - A request from side k while side k is in SIDE_GREEN or SIDE_YELLOW is ignored.
- Arbitration:
  - On the MAIN_GREEN→MAIN_YELLOW edge, `active_side` loads the first pending index, searching upward from (last served + 1) mod `N_SIDE` with wrap-around.
  - The last-served pointer resets so that the first search starts at 0.
- Reset, asserted at any point including mid-phase, sets:
  - state MAIN_GREEN, `time_remaining`=`t_main_min`;
  - `pending`=0, synchronizer flops=0;
  - `active_side`=0, and the last-served pointer set so the next search starts at 0.
- Reset output values:
  - `main_green`=1, `main_yellow`=0, `main_red`=0.
  - All `side_red`=1, all `side_yellow`=0, all `side_green`=0.

## Timing
- Lamps decode combinationally from the state register, so they change in the same cycle as the state.
- Sensor latency: a `car_async` rising edge reaches `pending` 3 clocks after it is sampled (2 sync flops plus the pending flop).
- A transition occurs on the first clock edge with `tick`=1 at which its condition holds.
- If a request and the exit tick coincide, the request is seen only once it is in `pending`; it is not used in the same cycle.
- With `tick` held at 0, all outputs and the timer are frozen. `pending` continues to update.
- Minimum full cycle: max(t_main_min,1) + 2·max(t_yellow,1) + 2·max(t_allred,1) + max(t_side,1) ticks.

## Structure
- Shared package `traffic_pkg` holds:
  - the state encoding localparams (3-bit);
  - the lamp one-hot encoding.
- One natural sub-module, `car_sensor_sync_n`: an `N_SIDE`-wide 2-FF synchronizer with synchronous active-low reset.
- The arbiter, timer and FSM stay in the top module.

## Test plan
Common setup: `N_SIDE`=2, `TW`=4, t_main_min=3, t_yellow=2, t_allred=1, t_side=4, `tick`=1 every cycle.
- **Reset:** hold `reset`=0 for 2 cycles → `main_green`=1, `side_red`=2'b11, `time_remaining`=3, `state`=MAIN_GREEN.
- **No requests:** 20 ticks with no `car_async` → stays MAIN_GREEN; `time_remaining` counts 3,2,1 then holds at 1.
- **Single request:** 1-cycle pulse on `car_async`[1] → `pending`[1] set 3 clocks later. Then MAIN_YELLOW for 2 ticks, all-red for 1, side 1 green for 4, side 1 yellow for 2, all-red for 1, then MAIN_GREEN for at least 3 ticks; `pending`[1] clears on SIDE_GREEN entry.
- **Round-robin:** both sensors pulsed together → side 0 served first, then MAIN_GREEN for 3 ticks, then side 1. Pulse both again → side 0 is served next.
- **Mid-phase reset:** `reset`=0 during side 1 SIDE_GREEN → next edge gives MAIN_GREEN, `pending`=0, `time_remaining`=3, both sides red.
- **Zero yellow and tick gating:** t_yellow=0 → each yellow phase lasts exactly 1 tick. With `tick` held at 0 for 10 cycles mid-SIDE_GREEN → lamps and `time_remaining` unchanged.
